child_msg_arbiter: RTL and testbench

//  Round-robin arbiter that merges NUM_CHILDREN child-FPGA control streams (64-bit ctrl messages)

---
 rtl/child_msg_arbiter_pkg.sv | 16 +
 rtl/child_msg_arbiter_rr_grant.sv | 31 +++
 rtl/child_msg_arbiter.sv | 108 ++++++++++
 tb/tb_child_msg_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/child_msg_arbiter_pkg.sv
// Shared message field positions and header codes for the child message arbiter.
// Pulled in by the grant helper and the top-level arbiter.
package child_msg_arbiter_pkg;

  localparam int MSG_DEST_MSB   = 63;
  localparam int MSG_DEST_LSB   = 56;
  localparam int MSG_HEADER_MSB = 55;
  localparam int MSG_HEADER_LSB = 48;

  localparam logic [7:0] HEADER_RESULT = 8'h06;

  function automatic logic [7:0] msg_header(input logic [63:0] m);
    return m[MSG_HEADER_MSB:MSG_HEADER_LSB];
  endfunction

endpackage

// File: rtl/child_msg_arbiter_rr_grant.sv
// Combinational round-robin pick: the first requester at or after ptr wins.
// Produces a one-hot grant, its encoded index and an any-request flag.
module child_msg_arbiter_rr_grant #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  int unsigned w_c;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_c   = 0;
    for (int k = 0; k < N; k++) begin
      w_c = (int'(i_ptr) + k) % N;
      if (!o_any && i_req[w_c]) begin
        o_any      = 1'b1;
        o_gnt[w_c] = 1'b1;
        o_idx      = PW'(w_c);
      end
    end
  end

endmodule

// File: rtl/child_msg_arbiter.sv
// Round-robin merge of child control streams into one registered upstream stream.
// Define ARB_SOURCE_TAG_EN to overwrite the dest field with the source child index.
module child_msg_arbiter
  import child_msg_arbiter_pkg::*;
#(
  parameter int NUM_CHILDREN    = 4,
  parameter int CTRL_FIFO_WIDTH = 64
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic [NUM_CHILDREN*CTRL_FIFO_WIDTH-1:0] data_from_child,
  input  logic [NUM_CHILDREN-1:0]                 valid_from_child,
  output logic [NUM_CHILDREN-1:0]                 ready_from_child,
  output logic [CTRL_FIFO_WIDTH-1:0]              data_out,
  output logic                                    valid_out,
  input  logic                                    ready_out,
  input  logic                                    results_clear,
  output logic [$clog2(NUM_CHILDREN+1)-1:0]       result_count,
  output logic                                    results_done
);

  localparam int N  = NUM_CHILDREN;
  localparam int W  = CTRL_FIFO_WIDTH;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1);

  logic [PW-1:0] r_ptr;
  logic [W-1:0]  r_data;
  logic          r_valid;
  logic [CW-1:0] r_cnt;

  logic [N-1:0]  w_gnt;
  logic [PW-1:0] w_idx;
  logic          w_any;
  logic          w_load;
  logic          w_xfer;
  logic          w_res;
  logic [W-1:0]  w_msg;
  logic [W-1:0]  w_fwd;
  logic [PW-1:0] w_ptr_nxt;
  logic [CW-1:0] w_cnt_base;
  logic [CW-1:0] w_cnt_nxt;

  child_msg_arbiter_rr_grant #(
    .N  (N),
    .PW (PW)
  ) u_grant (
    .i_req (valid_from_child),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_load = !r_valid || ready_out;
  assign w_xfer = w_any && w_load;

  assign ready_from_child = (reset_n && w_load) ? w_gnt : '0;

  always_comb begin
    w_msg = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt[i]) w_msg = w_msg | data_from_child[i*W +: W];
    end
  end

  always_comb begin
    w_fwd = w_msg;
`ifdef ARB_SOURCE_TAG_EN
    w_fwd[MSG_DEST_MSB:MSG_DEST_LSB] = 8'(w_idx);
`endif
  end

  assign w_ptr_nxt = (w_idx == PW'(N - 1)) ? '0 : w_idx + 1'b1;

  assign w_res = w_xfer && (msg_header(w_msg[63:0]) == HEADER_RESULT);

  // Clear wins first, then a same-cycle result counts from zero.
  always_comb begin
    w_cnt_base = results_clear ? '0 : r_cnt;
    w_cnt_nxt  = w_cnt_base;
    if (w_res && (w_cnt_base < CW'(N))) w_cnt_nxt = w_cnt_base + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_load) begin
        r_valid <= w_any;
        if (w_any) begin
          r_data <= w_fwd;
          r_ptr  <= w_ptr_nxt;
        end
      end
    end
  end

  assign data_out     = r_data;
  assign valid_out    = r_valid;
  assign result_count = r_cnt;
  assign results_done = (r_cnt == CW'(N));

endmodule

// File: tb/tb_child_msg_arbiter.sv
// Directed bench for child_msg_arbiter with a cycle-level reference model.
// Honours ARB_SOURCE_TAG_EN when the design is built with it.
module tb_child_msg_arbiter;

  localparam int N = 4;

  logic          clk;
  logic          reset_n;
  logic [255:0]  data_from_child;
  logic [3:0]    valid_from_child;
  logic [3:0]    ready_from_child;
  logic [63:0]   data_out;
  logic          valid_out;
  logic          ready_out;
  logic          results_clear;
  logic [2:0]    result_count;
  logic          results_done;

  logic [63:0] msg [N];

  int checks   = 0;
  int failures = 0;

  child_msg_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .data_from_child  (data_from_child),
    .valid_from_child (valid_from_child),
    .ready_from_child (ready_from_child),
    .data_out         (data_out),
    .valid_out        (valid_out),
    .ready_out        (ready_out),
    .results_clear    (results_clear),
    .result_count     (result_count),
    .results_done     (results_done)
  );

  always_comb begin
    data_from_child = '0;
    for (int i = 0; i < N; i++) data_from_child[i*64 +: 64] = msg[i];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] fwd(input int i, input logic [63:0] m);
    logic [63:0] r;
    r = m;
`ifdef ARB_SOURCE_TAG_EN
    r[63:56] = 8'(i);
`endif
    return r;
  endfunction

  function automatic int pick(input int p, input logic [3:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Reference model: state of the output slot, next-search start, result tally.
  logic        m_valid = 1'b0;
  logic [63:0] m_data  = '0;
  int          m_ptr   = 0;
  int          m_cnt   = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_ptr   = 0;
      m_cnt   = 0;
    end else begin
      int g;
      bit room;
      room = !m_valid || ready_out;
      g = pick(m_ptr, valid_from_child);
      if (results_clear) m_cnt = 0;
      if (room) begin
        if (g >= 0) begin
          if (msg[g][55:48] == 8'h06 && m_cnt < N) m_cnt++;
          m_data  = fwd(g, msg[g]);
          m_valid = 1'b1;
          m_ptr   = (g + 1) % N;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [3:0] er;
    #2;
    er = '0;
    g  = pick(m_ptr, valid_from_child);
    if (reset_n && (!m_valid || ready_out) && g >= 0) er[g] = 1'b1;
    chk("m_ready", 64'(ready_from_child), 64'(er));
    chk("m_valid", 64'(valid_out), 64'(m_valid));
    chk("m_data", data_out, m_data);
    chk("m_count", 64'(result_count), 64'(m_cnt));
    chk("m_done", 64'(results_done), 64'(m_cnt == N));
  end

  initial begin
    reset_n          = 1'b0;
    ready_out        = 1'b1;
    results_clear    = 1'b0;
    valid_from_child = 4'hF;
    for (int i = 0; i < N; i++)
      msg[i] = {8'(8'hA0 + i), 8'h01, 48'(48'h0000_1010_0000 + i)};

    // reset with everything requesting
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 64'(ready_from_child), 64'h0);
    chk("rst_valid", 64'(valid_out), 64'h0);
    chk("rst_count", 64'(result_count), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("first_grant", 64'(ready_from_child), 64'h1);

    // full-throughput rotation 0,1,2,3,0,...
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      #1;
      chk("rr_order", data_out, fwd(k % 4, msg[k % 4]));
    end
    ready_out = 1'b0;

    // backpressure: slot frozen on child 0 message
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("bp_data", data_out, fwd(0, msg[0]));
      chk("bp_ready", 64'(ready_from_child), 64'h0);
    end
    ready_out = 1'b1;
    #1;
    chk("bp_resume_grant", 64'(ready_from_child), 64'h2);
    @(negedge clk);
    #1;
    chk("bp_resume_data", data_out, fwd(1, msg[1]));
    valid_from_child = 4'h0;

    // result counting and saturation
    @(negedge clk);
    for (int i = 0; i < N; i++) msg[i][55:48] = 8'h06;
    valid_from_child = 4'hF;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      #1;
      chk("res_count", 64'(result_count), 64'(k));
    end
    chk("res_done", 64'(results_done), 64'h1);
    @(negedge clk);
    #1;
    chk("res_sat", 64'(result_count), 64'h4);
    results_clear = 1'b1;
    @(negedge clk);
    #1;
    chk("res_clear_count", 64'(result_count), 64'h1);
    chk("res_clear_done", 64'(results_done), 64'h0);
    results_clear    = 1'b0;
    valid_from_child = 4'h0;
    for (int i = 0; i < N; i++) msg[i][55:48] = 8'h01;
    @(negedge clk);

    // sparse requests and pointer wrap
    valid_from_child = 4'b0100;
    #1;
    chk("sp_grant2", 64'(ready_from_child), 64'h4);
    @(negedge clk);
    #1;
    chk("sp_data2", data_out, fwd(2, msg[2]));
    valid_from_child = 4'b0010;
    #1;
    chk("sp_grant1", 64'(ready_from_child), 64'h2);
    @(negedge clk);
    #1;
    chk("sp_valid1", 64'(valid_out), 64'h1);
    chk("sp_data1", data_out, fwd(1, msg[1]));
    valid_from_child = 4'b1001;
    #1;
    chk("sp_grant3", 64'(ready_from_child), 64'h8);
    @(negedge clk);
    #1;
    chk("sp_data3", data_out, fwd(3, msg[3]));
    chk("wrap_grant0", 64'(ready_from_child), 64'h1);
    @(negedge clk);
    #1;
    chk("wrap_data0", data_out, fwd(0, msg[0]));
    valid_from_child = 4'h0;
    @(negedge clk);

    // source tag / passthrough of dest field
    msg[3] = 64'hFF06_0000_0000_0012;
    valid_from_child = 4'b1000;
    @(negedge clk);
    #1;
`ifdef ARB_SOURCE_TAG_EN
    chk("tag_data", data_out, 64'h0306_0000_0000_0012);
`else
    chk("tag_data", data_out, 64'hFF06_0000_0000_0012);
`endif
    valid_from_child = 4'hF;
    @(negedge clk);

    // asynchronous reset drops the buffered message
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 64'(valid_out), 64'h0);
    chk("arst_ready", 64'(ready_from_child), 64'h0);
    chk("arst_count", 64'(result_count), 64'h0);
    chk("arst_data", data_out, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    valid_from_child = 4'h0;
    repeat (2) @(negedge clk);
    #4;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
